// File: rtl/timer_multi_ch.sv
// timer_multi_ch: NUM_CH independent prescaled down-counting timers with
// timeout interrupts, snapshot capture and PWM outputs, behind a simple
// word-addressed register slave ({channel, reg[2:0]}).
module timer_multi_ch #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 499999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         pwm_out
);

  localparam int ADDR_W = $clog2(NUM_CH) + 3;
  localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);

  // Per-channel register offsets
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_SNAP     = 3'd4;
  localparam logic [2:0] REG_PRESCALE = 3'd5;

  // CONTROL bit positions
  localparam int CTL_ITO    = 0;
  localparam int CTL_CONT   = 1;
  localparam int CTL_START  = 2;
  localparam int CTL_STOP   = 3;
  localparam int CTL_PWM_EN = 4;

  logic                     wr_en;
  logic [ADDR_W-1:0]        ch_sel;
  logic [2:0]               reg_sel;
  logic [NUM_CH-1:0][31:0]  ch_rdata;
  logic [NUM_CH-1:0]        irq_vec;
  logic [31:0]              rdata_d;
  logic [31:0]              rdata_q;

  assign wr_en   = chipselect & ~write_n;
  assign ch_sel  = address >> 3;
  assign reg_sel = address[2:0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             sel_ch;
    logic             wr_status;
    logic             wr_control;
    logic             wr_period;
    logic             wr_compare;
    logic             wr_snap;
    logic             wr_prescale;
    logic             tick;
    logic             timeout;
    logic [31:0]      rd_val;

    logic             run_q, run_d;
    logic             to_q, to_d;
    logic             ito_q, ito_d;
    logic             cont_q, cont_d;
    logic             pwm_en_q, pwm_en_d;
    logic             reload_q, reload_d;
    logic             pwm_q, pwm_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] compare_q, compare_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [PRE_W-1:0] p_q, p_d;

    assign sel_ch      = wr_en && (ch_sel == ADDR_W'(gi));
    assign wr_status   = sel_ch && (reg_sel == REG_STATUS);
    assign wr_control  = sel_ch && (reg_sel == REG_CONTROL);
    assign wr_period   = sel_ch && (reg_sel == REG_PERIOD);
    assign wr_compare  = sel_ch && (reg_sel == REG_COMPARE);
    assign wr_snap     = sel_ch && (reg_sel == REG_SNAP);
    assign wr_prescale = sel_ch && (reg_sel == REG_PRESCALE);

    // A tick fires when the running prescaler has counted up to PRESCALE;
    // a tick that finds the counter already at zero is a timeout.
    assign tick    = run_q && (p_q == presc_q);
    assign timeout = tick && (counter_q == '0);

    // Next-state: counting first, then register writes override RUN/p.
    always_comb begin
      counter_d = counter_q;
      period_d  = period_q;
      compare_d = compare_q;
      snap_d    = snap_q;
      presc_d   = presc_q;
      p_d       = p_q;
      run_d     = run_q;
      to_d      = to_q;
      ito_d     = ito_q;
      cont_d    = cont_q;
      pwm_en_d  = pwm_en_q;
      reload_d  = 1'b0;
      pwm_d     = pwm_en_q & run_q & (counter_q < compare_q);

      // A pending reload (from a PERIOD write) cannot coincide with RUN,
      // because that same write stopped the channel.
      if (reload_q) begin
        counter_d = period_q;
        p_d       = '0;
      end else if (run_q) begin
        p_d = tick ? '0 : p_q + PRE_W'(1);
        if (tick) begin
          counter_d = timeout ? period_q : counter_q - CNT_W'(1);
        end
      end

      // Clearing TO loses against a timeout on the same edge.
      if (wr_status) begin
        to_d = 1'b0;
      end
      if (timeout) begin
        to_d = 1'b1;
        if (!cont_q) begin
          run_d = 1'b0;
        end
      end

      if (wr_control) begin
        ito_d    = writedata[CTL_ITO];
        cont_d   = writedata[CTL_CONT];
        pwm_en_d = writedata[CTL_PWM_EN];
        if (writedata[CTL_START]) begin
          run_d = 1'b1;
          p_d   = '0;
        end else if (writedata[CTL_STOP]) begin
          run_d = 1'b0;
        end
      end

      if (wr_period) begin
        period_d = writedata[CNT_W-1:0];
        run_d    = 1'b0;
        reload_d = 1'b1;
      end

      if (wr_compare) begin
        compare_d = writedata[CNT_W-1:0];
      end

      if (wr_snap) begin
        snap_d = counter_q;
      end

      if (wr_prescale) begin
        presc_d = writedata[PRE_W-1:0];
      end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        counter_q <= RST_PER;
        period_q  <= RST_PER;
        compare_q <= '0;
        snap_q    <= '0;
        presc_q   <= '0;
        p_q       <= '0;
        run_q     <= 1'b0;
        to_q      <= 1'b0;
        ito_q     <= 1'b0;
        cont_q    <= 1'b0;
        pwm_en_q  <= 1'b0;
        reload_q  <= 1'b0;
        pwm_q     <= 1'b0;
      end else begin
        counter_q <= counter_d;
        period_q  <= period_d;
        compare_q <= compare_d;
        snap_q    <= snap_d;
        presc_q   <= presc_d;
        p_q       <= p_d;
        run_q     <= run_d;
        to_q      <= to_d;
        ito_q     <= ito_d;
        cont_q    <= cont_d;
        pwm_en_q  <= pwm_en_d;
        reload_q  <= reload_d;
        pwm_q     <= pwm_d;
      end
    end

    // Read view of this channel's registers, zero-extended to 32 bits
    always_comb begin
      rd_val = '0;
      case (reg_sel)
        REG_STATUS:   rd_val = {30'd0, run_q, to_q};
        REG_CONTROL:  rd_val = {27'd0, pwm_en_q, 2'b00, cont_q, ito_q};
        REG_PERIOD:   rd_val = 32'(period_q);
        REG_COMPARE:  rd_val = 32'(compare_q);
        REG_SNAP:     rd_val = 32'(snap_q);
        REG_PRESCALE: rd_val = 32'(presc_q);
        default:      rd_val = '0;
      endcase
    end

    assign ch_rdata[gi] = rd_val;
    assign irq_vec[gi]  = to_q & ito_q;
    assign pwm_out[gi]  = pwm_q;
  end

  // Channel select for the read path; unimplemented channels read zero
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == ADDR_W'(c)) begin
        rdata_d = ch_rdata[c];
      end
    end
  end

  // Read data is registered every clock, independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |irq_vec;

endmodule
